// File: rtl/matrix_pkg.sv
// matrix_pkg: shared constants, error codes and parser state encoding for the matrix UART path
package matrix_pkg;
  localparam int MAX_SIZE = 5;
  localparam int ELEM_MAX = 9;
  localparam logic [7:0] ASCII_0 = 8'h30;
  localparam logic [7:0] ASCII_9 = 8'h39;
  localparam logic [7:0] ASCII_SP = 8'h20;
  localparam logic [7:0] ASCII_CR = 8'h0D;
  localparam logic [7:0] ASCII_LF = 8'h0A;
  localparam logic [7:0] ASCII_COMMA = 8'h2C;
  localparam logic [1:0] ERR_BAD_CHAR = 2'd1;
  localparam logic [1:0] ERR_DIM = 2'd2;
  localparam logic [1:0] ERR_ELEM = 2'd3;
  typedef enum logic [2:0] {
    IDLE, GET_ROW, GET_COL, GET_ELEM, COMMIT, DONE, ERROR, WAIT_RELEASE
  } state_t;
endpackage

// File: rtl/ascii_dec_token.sv
// ascii_dec_token: classifies rx bytes and accumulates saturating decimal tokens
module ascii_dec_token import matrix_pkg::*; (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       en,
  input  logic       rx_valid,
  input  logic [7:0] rx_data,
  output logic       tok_done,
  output logic [7:0] tok_val,
  output logic       bad_char
);
  logic [7:0] acc;
  logic tok_active, is_dig, is_sep;
  logic [11:0] nxt;
  always_comb begin
    is_dig = rx_data >= ASCII_0 && rx_data <= ASCII_9;
    is_sep = rx_data == ASCII_SP || rx_data == ASCII_CR || rx_data == ASCII_LF || rx_data == ASCII_COMMA;
    nxt = {4'd0, acc} * 12'd10 + {8'd0, rx_data[3:0]};
    tok_done = en && rx_valid && is_sep && tok_active;
    bad_char = en && rx_valid && !is_dig && !is_sep;
    tok_val = acc;
  end
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      acc <= '0;
      tok_active <= 1'b0;
    end else if (!en || tok_done) begin
      acc <= '0;
      tok_active <= 1'b0;
    end else if (rx_valid && is_dig) begin
      acc <= nxt > 12'd255 ? 8'hFF : nxt[7:0];
      tok_active <= 1'b1;
    end
endmodule

// File: rtl/matrix_input_parser.sv
// matrix_input_parser: parses "rows cols e0 e1 ..." from UART bytes into matrix storage writes
module matrix_input_parser #(
  parameter int MAX_SIZE = matrix_pkg::MAX_SIZE,
  parameter int ELEM_MAX = matrix_pkg::ELEM_MAX,
  parameter int ELEM_WIDTH = 4
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  start_req,
  input  logic                  cancel,
  output logic                  busy,
  input  logic                  rx_valid,
  input  logic [7:0]            rx_data,
  output logic                  alloc_req,
  output logic [2:0]            alloc_row,
  output logic [2:0]            alloc_col,
  output logic                  wr_en,
  output logic [2:0]            wr_row,
  output logic [2:0]            wr_col,
  output logic [ELEM_WIDTH-1:0] wr_data,
  output logic                  commit,
  output logic                  abort,
  output logic                  done,
  output logic                  err,
  output logic [1:0]            err_code
);
  import matrix_pkg::*;
  state_t state, nxt;
  logic tok_done, bad_char, alloced, in_get, complete, dim_ok, elem_ok, fail, last_col;
  logic [7:0] tok_val;
  logic [2:0] r_idx, c_idx;
  ascii_dec_token u_tok (
    .clk(clk), .rst_n(rst_n), .en(in_get && !complete), .rx_valid(rx_valid), .rx_data(rx_data),
    .tok_done(tok_done), .tok_val(tok_val), .bad_char(bad_char)
  );
  // complete: every element written, so trailing bytes are ignored while COMMIT is entered
  always_comb begin
    in_get = state inside {GET_ROW, GET_COL, GET_ELEM};
    complete = state == GET_ELEM && r_idx == alloc_row;
    dim_ok = tok_val >= 8'd1 && tok_val <= 8'(MAX_SIZE);
    elem_ok = tok_val <= 8'(ELEM_MAX);
    last_col = c_idx + 3'd1 == alloc_col;
    fail = in_get && (cancel || bad_char || (tok_done && (state == GET_ELEM ? !elem_ok : !dim_ok)));
  end
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) state <= IDLE;
    else state <= nxt;
  always_comb begin
    nxt = state;
    case (state)
      IDLE: nxt = start_req ? GET_ROW : IDLE;
      GET_ROW: nxt = fail ? ERROR : tok_done ? GET_COL : GET_ROW;
      GET_COL: nxt = fail ? ERROR : tok_done ? GET_ELEM : GET_COL;
      GET_ELEM: nxt = fail ? ERROR : complete ? COMMIT : GET_ELEM;
      COMMIT: nxt = DONE;
      DONE, ERROR, WAIT_RELEASE: nxt = start_req ? WAIT_RELEASE : IDLE;
      default: nxt = IDLE;
    endcase
  end
  always_comb begin
    busy = state inside {GET_ROW, GET_COL, GET_ELEM, COMMIT, DONE, ERROR};
    commit = state == COMMIT;
    done = state == COMMIT;
    err = state == ERROR;
    abort = state == ERROR && alloced;
  end
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      alloc_req <= 1'b0;
      alloc_row <= '0;
      alloc_col <= '0;
      wr_en <= 1'b0;
      wr_row <= '0;
      wr_col <= '0;
      wr_data <= '0;
      err_code <= '0;
      alloced <= 1'b0;
      r_idx <= '0;
      c_idx <= '0;
    end else begin
      alloc_req <= 1'b0;
      wr_en <= 1'b0;
      if (state == IDLE && start_req) begin
        err_code <= '0;
        alloced <= 1'b0;
      end
      if (fail && !cancel) err_code <= bad_char ? ERR_BAD_CHAR : state == GET_ELEM ? ERR_ELEM : ERR_DIM;
      if (tok_done && !fail) begin
        if (state == GET_ROW) alloc_row <= tok_val[2:0];
        if (state == GET_COL) begin
          alloc_col <= tok_val[2:0];
          alloc_req <= 1'b1;
          alloced <= 1'b1;
          r_idx <= '0;
          c_idx <= '0;
        end
        if (state == GET_ELEM) begin
          wr_en <= 1'b1;
          wr_row <= r_idx;
          wr_col <= c_idx;
          wr_data <= tok_val[ELEM_WIDTH-1:0];
          c_idx <= last_col ? 3'd0 : c_idx + 3'd1;
          r_idx <= last_col ? r_idx + 3'd1 : r_idx;
        end
      end
    end
endmodule

// File: doc/matrix_input_parser.md
Name: matrix_input_parser

Overview:
- UART receive-side counterpart to the matrix list/display path.
- Consumes ASCII bytes from uart_rx after a start request and parses a decimal token stream: "rows cols e0 e1 … e(r*c-1)".
- Validates the stream and writes the elements row-major into multi-matrix storage through an alloc/write/commit/abort handshake.
- Reports completion or a coded error to the top-level controller.

Parameters:
- MAX_SIZE, 5, maximum rows and columns; valid dimensions are 1..MAX_SIZE.
- ELEM_MAX, 9, maximum element value; valid elements are 0..ELEM_MAX.
- ELEM_WIDTH, 4, width of wr_data.

Ports:
- clk  in  1  system clock
- rst_n  in  1  asynchronous active-low reset
- start_req  in  1  level/pulse; rising to 1 in IDLE begins a parse
- cancel  in  1  synchronous abort request
- busy  out  1  high from start accept until DONE/ERROR exit
- rx_valid  in  1  one-cycle strobe from uart_rx, one byte
- rx_data  in  8  received byte
- alloc_req  out  1  one-cycle pulse: storage reserves a slot of alloc_row x alloc_col
- alloc_row  out  3  parsed row count
- alloc_col  out  3  parsed column count
- wr_en  out  1  one-cycle element write strobe
- wr_row  out  3  element row index, 0-based
- wr_col  out  3  element column index, 0-based
- wr_data  out  ELEM_WIDTH  element value
- commit  out  1  one-cycle pulse: matrix complete, storage makes slot visible
- abort  out  1  one-cycle pulse: storage discards reserved slot
- done  out  1  one-cycle pulse on successful commit
- err  out  1  one-cycle pulse on error
- err_code  out  2  held until next start: 1 bad char, 2 dimension out of range, 3 element out of range

Behaviour:
- Reset: all outputs 0, state IDLE, accumulator and indices 0. Reset mid-parse drops everything with no abort pulse; storage resets with the same rst_n.

Byte classes:
- Digit: 0x30–0x39.
- Separator: space, CR (0x0D), LF (0x0A), comma.
- Anything else is a bad char.

Token accumulation:
- acc <= acc*10 + digit, 8-bit.
- A flag tok_active is set on the first digit.
- If acc would exceed 255, acc saturates at 255; this is caught by the range check.
- A separator with tok_active clear is ignored, so leading and repeated separators are allowed.
- A separator with tok_active set completes the token: the token is checked, then acc and tok_active are cleared.

State sequence (IDLE → GET_ROW → GET_COL → GET_ELEM → COMMIT → DONE → WAIT_RELEASE):
- IDLE: busy=0. On start_req=1, busy<=1, err_code<=0, go to GET_ROW.
- GET_ROW: on token completion:
  - if the token is in 1..MAX_SIZE, latch alloc_row and go to GET_COL;
  - otherwise go to ERROR with code 2.
- GET_COL: on token completion:
  - if the token is valid, latch alloc_col, pulse alloc_req in the next cycle, clear idx, and go to GET_ELEM;
  - otherwise go to ERROR with code 2.
- GET_ELEM: on token completion:
  - if the token is ≤ ELEM_MAX, pulse wr_en in the next cycle with wr_row/wr_col from the current index and wr_data = token, then advance the column index and wrap the row at alloc_col;
  - if the token is out of range, go to ERROR with code 3;
  - after the write with index r*c-1, go to COMMIT.
- COMMIT: pulse commit and done for one cycle, then go to DONE.
- DONE / ERROR exit:
  - if start_req is still 1, go to WAIT_RELEASE; otherwise go to IDLE;
  - busy<=0 on exit.
- ERROR: pulse err for one cycle.
  - If alloc_req was already issued, also pulse abort in the same cycle.
  - Then exit as for DONE.
- WAIT_RELEASE: stay until start_req=0, then go to IDLE.

Bad-char and cancel rules:
- A bad char in GET_ROW, GET_COL or GET_ELEM goes to ERROR with code 1.
- cancel in any busy state goes to ERROR with err_code unchanged (0), so abort applies as above.
- cancel has priority over a simultaneous rx_valid.

Byte acceptance and timing:
- Bytes are accepted every cycle in GET_* states, with no drop.
- rx_valid in IDLE, COMMIT, ERROR, DONE or WAIT_RELEASE is ignored.
- Latency from the terminating separator's rx_valid to the registered strobe (wr_en/alloc_req) is 1 cycle.
- commit is asserted 1 cycle after the last wr_en.
- A 1x1 matrix issues exactly one wr_en.
- Trailing bytes after the final element separator are ignored.
- A final element without a terminating separator is never written; use cancel to recover.

Decomposition:
- Shared package matrix_pkg:
  - MAX_SIZE and ELEM_MAX;
  - ASCII constants: ASCII_0, ASCII_9, ASCII_SP, ASCII_CR, ASCII_LF, ASCII_COMMA;
  - ERR_BAD_CHAR, ERR_DIM, ERR_ELEM codes;
  - parser state encodings.
- One natural sub-module: ascii_dec_token.
  - Handles digit/separator classification, the saturating accumulator and tok_active.
  - Outputs tok_done, tok_val[7:0] and bad_char as single-cycle strobes.

Test Plan:
- "2 3 1 2 3 4 5 6\n" after start → alloc_req(2,3), then six wr_en at (0,0)=1…(1,2)=6, then commit and done 1 cycle after the last write; err never asserted.
- "  1,,1\r\n7 " → alloc_req(1,1), one wr_en (0,0)=7, commit; repeated separators are tolerated.
- "6 2 " → err with err_code=2; no alloc_req or abort.
- "2 2 1 12 " → alloc_req(2,2), wr_en (0,0)=1, then err code 3 with abort in the same cycle; no commit.
- "3 x" → err code 1, no alloc_req. A separate run of "2 2 1 " followed by cancel → err, abort, err_code=0.
- start_req held high through a full "1 1 5 " parse → done, then WAIT_RELEASE and no restart. After start_req drops and rises again, a second parse runs. rst_n asserted mid-element → all outputs 0 immediately.
